// File: rtl/knn_sched.sv
// Query scheduler in front of a k-nearest-neighbour distance sorter.
// Round-robin issue, in-order tag tracking and a credit-limited result FIFO.
module knn_sched #(
  parameter int NUM_REQ   = 4,
  parameter int RES_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_addr,
  input  logic [63:0]                cfg_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][63:0]   req_query,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [63:0]                ds_query,
  output logic [63:0]                ds_search_0,
  output logic [63:0]                ds_search_1,
  output logic [63:0]                ds_search_2,
  output logic [63:0]                ds_search_3,
  output logic [63:0]                ds_search_4,
  output logic [63:0]                ds_search_5,
  output logic [63:0]                ds_search_6,
  output logic [63:0]                ds_search_7,
  output logic                       ds_in_valid,
  input  logic                       ds_out_valid,
  input  logic [2:0]                 ds_addr_1st,
  input  logic [2:0]                 ds_addr_2nd,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2:0]                 rsp_addr_1st,
  output logic [2:0]                 rsp_addr_2nd,
  output logic [4:0]                 inflight,
  output logic                       err_orphan
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(RES_DEPTH);
  localparam int RW  = IDW + 6;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [63:0]    bank    [8];
  logic [63:0]    ds_srch [8];

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic [NUM_REQ-1:0] grant;
  logic [4:0]     res_count;
  logic [5:0]     credit_sum;
  logic           can_issue;
  logic           accept;

  logic [IDW-1:0] tag_mem [RES_DEPTH];
  logic [PW-1:0]  tag_wr;
  logic [PW-1:0]  tag_rd;
  logic           tag_pop;
  logic           orphan;

  logic [RW-1:0]  res_mem [RES_DEPTH];
  logic [PW-1:0]  res_wr;
  logic [PW-1:0]  res_rd;
  logic           res_push;
  logic           res_pop;

  // Credits cover both in-flight work and buffered results so a
  // returning result always finds a free slot.
  always_comb begin
    credit_sum = {1'b0, inflight} + {1'b0, res_count};
    can_issue  = !rst && !cfg_we
                 && (credit_sum < 6'(RES_DEPTH));
  end

  always_comb begin
    int j;
    j       = 0;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(last_grant) + i) % NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
    if (can_issue && gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        bank[k] <= '0;
      end
    end else if (cfg_we) begin
      bank[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_in_valid <= 1'b0;
      ds_query    <= '0;
      last_grant  <= IDW'(NUM_REQ - 1);
      for (int k = 0; k < 8; k++) begin
        ds_srch[k] <= '0;
      end
    end else begin
      ds_in_valid <= accept;
      if (accept) begin
        ds_query   <= req_query[gnt_idx];
        last_grant <= gnt_idx;
        for (int k = 0; k < 8; k++) begin
          ds_srch[k] <= bank[k];
        end
      end
    end
  end

  assign ds_search_0 = ds_srch[0];
  assign ds_search_1 = ds_srch[1];
  assign ds_search_2 = ds_srch[2];
  assign ds_search_3 = ds_srch[3];
  assign ds_search_4 = ds_srch[4];
  assign ds_search_5 = ds_srch[5];
  assign ds_search_6 = ds_srch[6];
  assign ds_search_7 = ds_srch[7];

  // Tag occupancy equals inflight, so no separate tag counter.
  assign tag_pop = ds_out_valid && (inflight != 5'd0);
  assign orphan  = ds_out_valid && (inflight == 5'd0);

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tag_wr] <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr     <= '0;
      tag_rd     <= '0;
      inflight   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) begin
        tag_wr <= nxt(tag_wr);
      end
      if (tag_pop) begin
        tag_rd <= nxt(tag_rd);
      end
      if (orphan) begin
        err_orphan <= 1'b1;
      end
      unique case ({accept, tag_pop})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign res_push  = tag_pop;
  assign rsp_valid = (res_count != 5'd0);
  assign res_pop   = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (res_push) begin
      res_mem[res_wr] <= {tag_mem[tag_rd], ds_addr_1st, ds_addr_2nd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_wr    <= '0;
      res_rd    <= '0;
      res_count <= '0;
    end else begin
      if (res_push) begin
        res_wr <= nxt(res_wr);
      end
      if (res_pop) begin
        res_rd <= nxt(res_rd);
      end
      unique case ({res_push, res_pop})
        2'b10:   res_count <= res_count + 5'd1;
        2'b01:   res_count <= res_count - 5'd1;
        default: res_count <= res_count;
      endcase
    end
  end

  assign {rsp_id, rsp_addr_1st, rsp_addr_2nd} = res_mem[res_rd];

endmodule

// File: doc/knn_sched.md
KNN_SCHED -- requirements
Module: knn_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of query requesters; legal range 2..8.
REQ-002 Parameter RES_DEPTH, default 8: result FIFO depth and maximum outstanding operations; legal range 2..16.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cfg_we  input  1  search-bank write strobe.
REQ-006 cfg_addr  input  3  search-bank slot 0..7.
REQ-007 cfg_data  input  64  search-vector value.
REQ-008 req_valid  input  NUM_REQ  per-requester query valid.
REQ-009 req_query  input  NUM_REQ x 64  per-requester query vector.
REQ-010 req_ready  output  NUM_REQ  one-hot grant, combinational.
REQ-011 ds_query  output  64  registered query to dist_sort.
REQ-012 ds_search_0..ds_search_7  output  64 each  registered search vectors to dist_sort.
REQ-013 ds_in_valid  output  1  registered issue strobe to dist_sort.
REQ-014 ds_out_valid  input  1  dist_sort result strobe.
REQ-015 ds_addr_1st, ds_addr_2nd  input  3 each  dist_sort nearest and second-nearest slot.
REQ-016 rsp_valid  output  1  response FIFO non-empty.
REQ-017 rsp_ready  input  1  response consumer accept.
REQ-018 rsp_id  output  clog2(NUM_REQ)  originating requester.
REQ-019 rsp_addr_1st, rsp_addr_2nd  output  3 each  result slots.
REQ-020 inflight  output  5  operations issued but not yet returned by dist_sort.
REQ-021 err_orphan  output  1  sticky flag for a result with no pending tag.

Function
REQ-022 Search bank: 8 x 64-bit registers; cfg_we writes cfg_data to slot cfg_addr at the clock edge.
REQ-023 Credit rule: an issue is allowed only when inflight + res_count < RES_DEPTH and cfg_we=0.
REQ-024 Arbitration is round-robin: search starts at last_grant+1 modulo NUM_REQ; the first asserted req_valid gets req_ready when issue is allowed; all other req_ready bits are 0.
REQ-025 req_ready never depends on rsp_ready within the same cycle.
REQ-026 Accept at cycle t (req_valid & req_ready): at t+1 ds_in_valid=1, ds_query = the granted query, and ds_search_k = bank slot k as sampled at t; last_grant updates to the granted index.
REQ-027 ds_in_valid is 0 in every cycle after a cycle with no accept.
REQ-028 A bank write at t never alters ds_search outputs already issued, and it is visible to issues accepted at t+1 or later.
REQ-029 Tag FIFO (depth RES_DEPTH): the granted ID is pushed on accept and popped on ds_out_valid; results return in issue order.
REQ-030 On ds_out_valid with tags pending, write {popped tag, ds_addr_1st, ds_addr_2nd} to the result FIFO; rsp_valid rises the next cycle.
REQ-031 On ds_out_valid with the tag FIFO empty, set err_orphan, write nothing, and leave inflight unchanged.
REQ-032 inflight increments on accept and decrements on a non-orphan ds_out_valid; when both occur in the same cycle, inflight is unchanged.
REQ-033 Result FIFO: first-word-fall-through; rsp_* = head entry; pop on rsp_valid & rsp_ready; simultaneous push and pop are legal at any occupancy, including full; the count stays the same when both occur.
REQ-034 The credit rule guarantees the result FIFO never overflows; no result is ever dropped.
REQ-035 Pointers wrap modulo RES_DEPTH.

Reset
REQ-036 While rst=1 at an edge:
  - req_ready=0, ds_in_valid=0, rsp_valid=0, inflight=0, err_orphan=0
  - ds_query, ds_search_*, and bank = 0
  - both FIFOs empty
  - last_grant=NUM_REQ-1, so requester 0 wins first
REQ-037 Reset mid-operation discards all pending tags and results; ds_out_valid pulses arriving after reset set err_orphan.

Verification
REQ-038 Load bank slots k=0..7 with 64'h10*k; requester 2 issues query 64'h5 at t -> ds_in_valid=1 at t+1 with ds_search_3=64'h30; ds_out_valid returning 1st=0, 2nd=1 -> rsp_id=2, rsp_addr_1st=0, rsp_addr_2nd=1.
REQ-039 All 4 requesters valid continuously -> grant order 0,1,2,3,0,...; each requester receives exactly one grant per 4 accepts.
REQ-040 rsp_ready=0, RES_DEPTH=8, dist_sort latency 3 -> exactly 8 accepts, then req_ready=0 until rsp_ready=1; then one accept per pop; no result lost.
REQ-041 cfg_we=1 to slot 0 in the same cycle as req_valid -> no grant that cycle; the next-cycle issue carries the new slot 0 value.
REQ-042 ds_out_valid pulsed once with inflight=0 -> err_orphan=1 and stays 1; rsp_valid stays 0.
REQ-043 rst asserted with 3 operations in flight -> next cycle inflight=0, rsp_valid=0; round-robin restarts at requester 0.
